// File: rtl/byte_to_word_splitter_if.sv
// Request/response bus between the CPU load/store port, the splitter and
// the cache. The slave modport is the splitter's view; the master modport is the driver's view.
interface byte_to_word_splitter_if #(
    parameter int ADDR_W = 27
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_size;
    logic              in_we;
    logic [31:0]       in_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-3:0] out_addr;
    logic [3:0]        out_be;
    logic              out_we;
    logic [31:0]       out_wdata;
    logic              out_last;
    logic              out_split;
    logic              err;

    modport slave (
        input  in_valid, in_addr, in_size, in_we, in_wdata, out_ready,
        output in_ready, out_valid, out_addr, out_be, out_we, out_wdata,
               out_last, out_split, err
    );

    modport master (
        output in_valid, in_addr, in_size, in_we, in_wdata, out_ready,
        input  in_ready, out_valid, out_addr, out_be, out_we, out_wdata,
               out_last, out_split, err
    );
endinterface

// File: rtl/byte_to_word_splitter.sv
// Byte-addressed CPU request to word-addressed cache request converter.
// Misaligned accesses that straddle a word boundary are issued as two beats.

// One byte lane of the 8-byte window spanning the base word and the next word.
module byte_to_word_splitter_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  off,
    input  logic [2:0]  nbytes,
    input  logic [31:0] wdata,
    output logic        en,
    output logic [7:0]  data
);
    logic [3:0] lane_idx;
    logic [3:0] k;
    logic       ge;

    always_comb begin
        lane_idx = 4'(LANE);
        ge       = lane_idx >= {2'b00, off};
        k        = lane_idx - {2'b00, off};
        en       = ge && (k < {1'b0, nbytes});
        // Shifted write data is not masked by size, so all four source bytes land.
        data     = (ge && (k < 4'd4)) ? wdata[{k[1:0], 3'b000} +: 8] : 8'h00;
    end
endmodule

module byte_to_word_splitter #(
    parameter int ADDR_W = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    byte_to_word_splitter_if.slave bus
);
    localparam int NUM_LANES = 8;
    localparam int WA_W      = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    typedef struct packed {
        logic [WA_W-1:0] addr;
        logic [3:0]      be;
        logic [31:0]     wdata;
    } beat_t;

    state_t state, state_n;
    beat_t  cur, cur_n, nxt, nxt_n;
    logic   vld, vld_n, last, last_n, split, split_n, we, we_n, err, err_n;

    logic [1:0]                  off;
    logic [2:0]                  nbytes;
    logic [NUM_LANES-1:0]        mask8;
    logic [NUM_LANES-1:0][7:0]   data64;
    logic [WA_W-1:0]             waddr;
    beat_t                       dec0, dec1;
    logic                        dec_split;

    assign off   = bus.in_addr[1:0];
    assign waddr = bus.in_addr[ADDR_W-1:2];

    always_comb begin
        case (bus.in_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        byte_to_word_splitter_lane #(.LANE(i)) u_lane (
            .off    (off),
            .nbytes (nbytes),
            .wdata  (bus.in_wdata),
            .en     (mask8[i]),
            .data   (data64[i])
        );
    end

    always_comb begin
        dec0.addr  = waddr;
        dec0.be    = mask8[3:0];
        dec0.wdata = data64[3:0];
        // Word address wraps naturally at WA_W bits.
        dec1.addr  = waddr + 1'b1;
        dec1.be    = mask8[7:4];
        dec1.wdata = data64[7:4];
        dec_split  = |mask8[7:4];
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        nxt_n   = nxt;
        vld_n   = vld;
        last_n  = last;
        split_n = split;
        we_n    = we;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_size == 2'd3) begin
                        err_n = 1'b1;
                    end else begin
                        cur_n   = dec0;
                        nxt_n   = dec1;
                        vld_n   = 1'b1;
                        split_n = dec_split;
                        last_n  = !dec_split;
                        we_n    = bus.in_we;
                        state_n = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (bus.out_ready) begin
                    if (split) begin
                        cur_n   = nxt;
                        last_n  = 1'b1;
                        state_n = BEAT1;
                    end else begin
                        vld_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            BEAT1: begin
                if (bus.out_ready) begin
                    vld_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                vld_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            nxt   <= '0;
            vld   <= 1'b0;
            last  <= 1'b0;
            split <= 1'b0;
            we    <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            nxt   <= nxt_n;
            vld   <= vld_n;
            last  <= last_n;
            split <= split_n;
            we    <= we_n;
            err   <= err_n;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = vld;
    assign bus.out_addr  = cur.addr;
    assign bus.out_be    = cur.be;
    assign bus.out_wdata = cur.wdata;
    assign bus.out_we    = we;
    assign bus.out_last  = last;
    assign bus.out_split = split;
    assign bus.err       = err;
endmodule

// File: tb/tb_byte_to_word_splitter.sv
// Directed bench for byte_to_word_splitter with hand-computed expectations.
module tb_byte_to_word_splitter;
    localparam int ADDR_W = 27;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    byte_to_word_splitter_if #(.ADDR_W(ADDR_W)) bus ();

    byte_to_word_splitter #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [24:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input logic last, input logic split, input logic we);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".addr"},  64'(bus.out_addr),  64'(a));
        chk({tag, ".be"},    64'(bus.out_be),    64'(be));
        chk({tag, ".wdata"}, 64'(bus.out_wdata), 64'(wd));
        chk({tag, ".last"},  64'(bus.out_last),  64'(last));
        chk({tag, ".split"}, 64'(bus.out_split), 64'(split));
        chk({tag, ".we"},    64'(bus.out_we),    64'(we));
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".addr"},  64'(bus.out_addr),  64'd0);
        chk({tag, ".be"},    64'(bus.out_be),    64'd0);
        chk({tag, ".wdata"}, 64'(bus.out_wdata), 64'd0);
        chk({tag, ".we"},    64'(bus.out_we),    64'd0);
        chk({tag, ".last"},  64'(bus.out_last),  64'd0);
        chk({tag, ".split"}, 64'(bus.out_split), 64'd0);
        chk({tag, ".err"},   64'(bus.err),       64'd0);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic issue(input logic [26:0] a, input logic [1:0] sz, input logic we, input logic [31:0] wd);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_size  = sz;
        bus.in_we    = we;
        bus.in_wdata = wd;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_size   = '0;
        bus.in_we     = 1'b0;
        bus.in_wdata  = '0;
        bus.out_ready = 1'b0;
        #3;
        chk_idle_zero("reset");
        #9 rst_n = 1'b1;
        step();

        // Aligned word write
        bus.out_ready = 1'b1;
        issue(27'h0000010, 2'd2, 1'b1, 32'hAABBCCDD);
        chk_beat("t1.b0", 25'h4, 4'b1111, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1);
        step();
        chk("t1.done_valid", 64'(bus.out_valid), 64'd0);
        chk("t1.done_ready", 64'(bus.in_ready), 64'd1);

        // Misaligned word write splits
        issue(27'h0000006, 2'd2, 1'b1, 32'hAABBCCDD);
        chk_beat("t2.b0", 25'h1, 4'b1100, 32'hCCDD0000, 1'b0, 1'b1, 1'b1);
        step();
        chk_beat("t2.b1", 25'h2, 4'b0011, 32'h0000AABB, 1'b1, 1'b1, 1'b1);
        step();
        chk("t2.done_valid", 64'(bus.out_valid), 64'd0);

        // Half crossing a boundary under backpressure
        bus.out_ready = 1'b0;
        issue(27'h0000007, 2'd1, 1'b1, 32'h00001234);
        chk_beat("t3.b0", 25'h1, 4'b1000, 32'h34000000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_beat("t3.hold", 25'h1, 4'b1000, 32'h34000000, 1'b0, 1'b1, 1'b1);
        end
        bus.out_ready = 1'b1;
        step();
        chk_beat("t3.b1", 25'h2, 4'b0001, 32'h00000012, 1'b1, 1'b1, 1'b1);
        step();
        chk("t3.done_valid", 64'(bus.out_valid), 64'd0);

        // Word address wrap on a read
        issue(27'h7FFFFFD, 2'd2, 1'b0, 32'h11223344);
        chk_beat("t4.b0", 25'h1FFFFFF, 4'b1110, 32'h22334400, 1'b0, 1'b1, 1'b0);
        step();
        chk_beat("t4.b1", 25'h0000000, 4'b0001, 32'h00000011, 1'b1, 1'b1, 1'b0);
        step();
        chk("t4.done_valid", 64'(bus.out_valid), 64'd0);

        // Illegal size pulses err once, then a byte read
        issue(27'h0000004, 2'd3, 1'b0, 32'h0);
        chk("t5.err", 64'(bus.err), 64'd1);
        chk("t5.valid", 64'(bus.out_valid), 64'd0);
        chk("t5.ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("t5.err_clr", 64'(bus.err), 64'd0);
        chk("t5.valid2", 64'(bus.out_valid), 64'd0);
        issue(27'h0000003, 2'd0, 1'b0, 32'h00000055);
        chk_beat("t5.byte", 25'h0, 4'b1000, 32'h55000000, 1'b1, 1'b0, 1'b0);
        step();
        chk("t5.done_valid", 64'(bus.out_valid), 64'd0);

        // Async reset in the middle of a split request
        bus.out_ready = 1'b0;
        issue(27'h0000006, 2'd2, 1'b1, 32'hAABBCCDD);
        chk_beat("t6.b0", 25'h1, 4'b1100, 32'hCCDD0000, 1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_zero("t6.rst");
        #1 bus.out_ready = 1'b1;
        #2 rst_n = 1'b1;
        step();
        chk("t6.post_valid0", 64'(bus.out_valid), 64'd0);
        chk("t6.post_ready0", 64'(bus.in_ready), 64'd1);
        step();
        chk("t6.post_valid1", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_to_word_splitter.md
Name: byte_to_word_splitter

Overview:
Converts byte-addressed CPU requests into word-addressed cache requests. This is the inverse of the word-to-byte address shift used on the cache side. It strips the 2-bit byte offset, generates byte enables and aligns write data into word lanes. Accesses that cross a 32-bit word boundary are split into two sequential word requests. It sits between the CPU load/store port and the set-associative cache request port.

Parameters:
ADDR_W, 27, byte address width; the word address width is ADDR_W-2 (default 25).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
in_addr  input  ADDR_W  byte address.
in_size  input  2  access size: 0=byte, 1=half, 2=word, 3=illegal.
in_we  input  1  1=write, 0=read.
in_wdata  input  32  write data, right-justified.
out_valid  output  1  word request valid.
out_ready  input  1  cache accepts the word request.
out_addr  output  ADDR_W-2  word address.
out_be  output  4  byte enables; bit i enables byte lane i.
out_we  output  1  write flag, copied from the request.
out_wdata  output  32  lane-aligned write data.
out_last  output  1  final beat of the current request.
out_split  output  1  current request has two beats.
err  output  1  one-cycle pulse on an illegal size.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - in_ready=1.
  - out_valid=0, out_addr=0, out_be=0, out_we=0, out_wdata=0, out_last=0, out_split=0, err=0.
- Decode on accept:
  - off = in_addr[1:0]; waddr = in_addr[ADDR_W-1:2].
  - nbytes = 1, 2 or 4 for sizes 0, 1, 2.
  - mask8 = ((1<<nbytes)-1) << off, an 8-bit value.
  - data64 = {32'b0, in_wdata} << (8*off).
  - Beat0: addr=waddr, be=mask8[3:0], wdata=data64[31:0].
  - Beat1 exists iff mask8[7:4]!=0: addr=waddr+1, be=mask8[7:4], wdata=data64[63:32].
- Word address wrap: waddr+1 is taken modulo 2^(ADDR_W-2), so all-ones+1 = 0. There is no error on wrap.
- State machine:
  - IDLE: in_ready=1.
    - On in_valid with size 0-2: register beat0, set out_valid=1 and out_split, set out_last=!split, and go to BEAT0.
    - On in_valid with size 3: pulse err for one cycle, produce no output, stay in IDLE.
  - BEAT0: in_ready=0; hold all outputs stable while out_ready=0.
    - On out_ready with split=0: out_valid=0, go to IDLE.
    - On out_ready with split=1: load beat1 in the same cycle, set out_last=1, go to BEAT1.
  - BEAT1: in_ready=0; hold outputs until out_ready, then out_valid=0 and go to IDLE.
- Latency and throughput:
  - One cycle from the accept edge to out_valid=1.
  - Minimum 2 cycles per aligned request and 3 per split request, because in_ready deasserts after each accept.
- Read requests: out_wdata is still computed, and out_be marks the bytes that are requested.
- Registered outputs are stable whenever out_valid=1 and out_ready=0.
- Reset asserted mid-operation aborts any pending beat immediately. No partial beat is emitted after rst_n is released.
- out_split and out_we remain constant across both beats of a request.

Test Plan:
- Aligned word write: addr=0x0000010, size=2, wdata=0xAABBCCDD, out_ready=1. Expect one beat: out_addr=0x4, be=1111, wdata=0xAABBCCDD, last=1, split=0.
- Misaligned word write: addr=0x0000006, size=2, wdata=0xAABBCCDD. Expect beat0 addr=0x1, be=1100, wdata=0xCCDD0000, last=0, split=1; then beat1 addr=0x2, be=0011, wdata=0x0000AABB, last=1.
- Half crossing a boundary with backpressure: addr=0x0000007, size=1, wdata=0x1234, out_ready=0 for 3 cycles. Expect beat0 held stable with addr=0x1, be=1000, wdata=0x34000000. After out_ready=1: beat1 addr=0x2, be=0001, wdata=0x00000012. in_ready=0 throughout.
- Address wrap: addr=0x7FFFFFD, size=2, read. Expect beat0 addr=0x1FFFFFF, be=1110; beat1 addr=0x0000000, be=0001, last=1.
- Illegal size and byte read: size=3 gives an err pulse of exactly 1 cycle, out_valid stays 0 and in_ready stays 1. Next, addr=0x0000003, size=0 gives a single beat addr=0x0, be=1000.
- Reset mid-split: assert rst_n=0 while in BEAT0 of a split request. Expect out_valid=0 and all outputs 0 immediately (asynchronous), in_ready=1 after release, and no beat1 issued.
